roster_capture: RTL and testbench

- Downstream consumer of the player-registry block's list stream (`listMode`/`listOut`).
- Captures one list burst into a local buffer and compacts out empty (4'b0000) slots.
- Reports the roster count, flags malformed bursts, then cycles the captured IDs onto a display port, holding each ID for a fixed dwell time.
- Sits between the registry and the board display/LED logic.

---
 rtl/roster_capture.sv | 185 ++++++++++++++++++
 tb/tb_roster_capture.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/roster_capture.sv
// Captures one registry list burst, compacts out empty slots, reports the roster and cycles IDs onto a display port.
// Optional duplicate rejection with a dupWng flag is enabled by defining ROSTER_DUP_CHECK_EN.
module roster_capture #(
  parameter int DEPTH = 5,
  parameter int DWELL = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               listMode,
  input  logic [3:0]         listOut,
  input  logic               team,
  output logic               rosterValid,
  output logic [2:0]         rosterCount,
  output logic [4*DEPTH-1:0] rosterFlat,
  output logic [3:0]         dispID,
  output logic [2:0]         dispIdx,
  output logic               dispActive,
  output logic               ovfWng,
`ifdef ROSTER_DUP_CHECK_EN
  output logic               dupWng,
`endif
  output logic               teamErr,
  output logic [1:0]         o_dbg_state
);

  localparam int CW  = 3;
  localparam int BW  = $clog2(DEPTH + 1);
  localparam int DWW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DISPLAY = 2'd2
  } state_t;

  state_t             r_state;
  logic [BW-1:0]      r_beats;
  logic               r_team;
  logic [4*DEPTH-1:0] r_flat;
  logic [CW-1:0]      r_count;
  logic               r_ovf;
  logic               r_terr;
  logic               r_valid;
  logic [3:0]         r_disp_id;
  logic [CW-1:0]      r_disp_idx;
  logic               r_disp_active;
  logic [DWW-1:0]     r_dwell;
`ifdef ROSTER_DUP_CHECK_EN
  logic               r_dup;
`endif

  logic               w_capt;
  logic               w_team_ref;
  logic [CW-1:0]      w_base_count;
  logic [4*DEPTH-1:0] w_base_flat;
  logic               w_nonempty;
  logic               w_team_bad;
  logic               w_dup_hit;
  logic               w_accept;
  logic [4*DEPTH-1:0] w_flat_next;
  logic [CW-1:0]      w_count_next;
  logic [CW-1:0]      w_next_idx;
  logic [3:0]         w_next_id;

  // listMode is a valid with no backpressure: every cycle it is high one entry is consumed.
  // A beat seen outside CAPTURE starts a fresh burst, so it is processed against an empty roster.
  always_comb begin
    w_capt       = (r_state == S_CAPTURE);
    w_team_ref   = w_capt ? r_team : team;
    w_base_count = w_capt ? r_count : '0;
    w_base_flat  = w_capt ? r_flat : '0;
    w_nonempty   = |listOut;
    w_team_bad   = w_nonempty && (listOut[3] != w_team_ref);
    w_dup_hit    = 1'b0;
`ifdef ROSTER_DUP_CHECK_EN
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < w_base_count) && (w_base_flat[i*4 +: 4] == listOut)) w_dup_hit = 1'b1;
    end
`endif
    w_accept    = w_nonempty && !w_team_bad && !w_dup_hit;
    w_flat_next = w_base_flat;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_accept && (CW'(i) == w_base_count)) w_flat_next[i*4 +: 4] = listOut;
    end
    w_count_next = w_base_count + {{(CW-1){1'b0}}, w_accept};

    w_next_idx = (r_disp_idx == (r_count - CW'(1))) ? '0 : (r_disp_idx + CW'(1));
    w_next_id  = 4'h0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) == w_next_idx) w_next_id = r_flat[i*4 +: 4];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state       <= S_IDLE;
      r_beats       <= '0;
      r_team        <= 1'b0;
      r_flat        <= '0;
      r_count       <= '0;
      r_ovf         <= 1'b0;
      r_terr        <= 1'b0;
      r_valid       <= 1'b0;
      r_disp_id     <= 4'h0;
      r_disp_idx    <= '0;
      r_disp_active <= 1'b0;
      r_dwell       <= '0;
`ifdef ROSTER_DUP_CHECK_EN
      r_dup         <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_DISPLAY: begin
          if (listMode) begin
            r_state       <= S_CAPTURE;
            r_team        <= team;
            r_beats       <= BW'(1);
            r_flat        <= w_flat_next;
            r_count       <= w_count_next;
            r_ovf         <= 1'b0;
            r_terr        <= w_team_bad;
            r_disp_id     <= 4'h0;
            r_disp_idx    <= '0;
            r_disp_active <= 1'b0;
            r_dwell       <= '0;
`ifdef ROSTER_DUP_CHECK_EN
            r_dup         <= w_dup_hit;
`endif
          end else if (r_state == S_DISPLAY) begin
            if (r_dwell == DWW'(DWELL - 1)) begin
              r_dwell    <= '0;
              r_disp_idx <= w_next_idx;
              r_disp_id  <= w_next_id;
            end else begin
              r_dwell <= r_dwell + DWW'(1);
            end
          end
        end
        S_CAPTURE: begin
          if (listMode) begin
            // Beats past DEPTH come from the upstream index overrunning; drop them and flag it.
            if (r_beats == BW'(DEPTH)) begin
              r_ovf <= 1'b1;
            end else begin
              r_beats <= r_beats + BW'(1);
              r_flat  <= w_flat_next;
              r_count <= w_count_next;
              r_terr  <= r_terr | w_team_bad;
`ifdef ROSTER_DUP_CHECK_EN
              r_dup   <= r_dup | w_dup_hit;
`endif
            end
          end else begin
            r_valid <= 1'b1;
            r_dwell <= '0;
            r_disp_idx <= '0;
            if (r_count != '0) begin
              r_state       <= S_DISPLAY;
              r_disp_active <= 1'b1;
              r_disp_id     <= r_flat[3:0];
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rosterValid = r_valid;
  assign rosterCount = r_count;
  assign rosterFlat  = r_flat;
  assign dispID      = r_disp_id;
  assign dispIdx     = r_disp_idx;
  assign dispActive  = r_disp_active;
  assign ovfWng      = r_ovf;
  assign teamErr     = r_terr;
  assign o_dbg_state = r_state;
`ifdef ROSTER_DUP_CHECK_EN
  assign dupWng      = r_dup;
`endif

endmodule

// File: tb/tb_roster_capture.sv
// Directed bench for roster_capture: compaction, display cycling, empty/overflow/team-error bursts,
// restart during display and mid-burst reset; duplicate rejection when ROSTER_DUP_CHECK_EN is defined.
module tb_roster_capture;

  localparam int DEPTH = 5;
  localparam int DWELL = 4;

  logic               CLK;
  logic               RST_N;
  logic               listMode;
  logic [3:0]         listOut;
  logic               team;
  logic               rosterValid;
  logic [2:0]         rosterCount;
  logic [4*DEPTH-1:0] rosterFlat;
  logic [3:0]         dispID;
  logic [2:0]         dispIdx;
  logic               dispActive;
  logic               ovfWng;
  logic               teamErr;
  logic [1:0]         o_dbg_state;
`ifdef ROSTER_DUP_CHECK_EN
  logic               dupWng;
`endif

  int n_cmp;
  int n_fail;
  logic [3:0] disp_seq [3];

  roster_capture #(.DEPTH(DEPTH), .DWELL(DWELL)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .listMode    (listMode),
    .listOut     (listOut),
    .team        (team),
    .rosterValid (rosterValid),
    .rosterCount (rosterCount),
    .rosterFlat  (rosterFlat),
    .dispID      (dispID),
    .dispIdx     (dispIdx),
    .dispActive  (dispActive),
    .ovfWng      (ovfWng),
`ifdef ROSTER_DUP_CHECK_EN
    .dupWng      (dupWng),
`endif
    .teamErr     (teamErr),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver
  task automatic beat(input logic [3:0] data, input logic tm);
    listMode = 1'b1;
    listOut  = data;
    team     = tm;
    tick();
  endtask

  task automatic end_burst();
    listMode = 1'b0;
    listOut  = 4'h0;
    tick();
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    RST_N    = 1'b0;
    listMode = 1'b0;
    listOut  = 4'h0;
    team     = 1'b0;
    disp_seq[0] = 4'h3;
    disp_seq[1] = 4'h5;
    disp_seq[2] = 4'h1;
    tick();
    tick();
    check("rst_valid", 32'(rosterValid), 32'h0);
    check("rst_count", 32'(rosterCount), 32'h0);
    check("rst_flat", 32'(rosterFlat), 32'h0);
    check("rst_active", 32'(dispActive), 32'h0);
    check("rst_state", 32'(o_dbg_state), 32'h0);
    check("rst_flags", 32'({ovfWng, teamErr}), 32'h0);
    RST_N = 1'b1;
    tick();

    // compaction: 3,0,5,0,1 -> 1,5,3 packed
    beat(4'h3, 1'b0);
    check("cmp_state_capture", 32'(o_dbg_state), 32'h1);
    beat(4'h0, 1'b0);
    beat(4'h5, 1'b0);
    beat(4'h0, 1'b0);
    beat(4'h1, 1'b0);
    check("cmp_no_valid_mid", 32'(rosterValid), 32'h0);
    end_burst();
    check("cmp_valid", 32'(rosterValid), 32'h1);
    check("cmp_count", 32'(rosterCount), 32'h3);
    check("cmp_flat", 32'(rosterFlat), 32'h00153);
    check("cmp_active", 32'(dispActive), 32'h1);
    check("cmp_disp0", 32'(dispID), 32'h3);
    check("cmp_state_display", 32'(o_dbg_state), 32'h2);
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 1) check("cmp_valid_pulse", 32'(rosterValid), 32'h0);
      check("cmp_disp_id", 32'(dispID), 32'(disp_seq[(k / DWELL) % 3]));
      check("cmp_disp_idx", 32'(dispIdx), 32'((k / DWELL) % 3));
    end

    // overflow, started from DISPLAY
    beat(4'h9, 1'b1);
    check("ovf_restart_active", 32'(dispActive), 32'h0);
    check("ovf_restart_id", 32'(dispID), 32'h0);
    check("ovf_restart_state", 32'(o_dbg_state), 32'h1);
    beat(4'hA, 1'b1);
    beat(4'hB, 1'b1);
    beat(4'hC, 1'b1);
    beat(4'hD, 1'b1);
    check("ovf_not_yet", 32'(ovfWng), 32'h0);
    beat(4'hE, 1'b1);
    check("ovf_set", 32'(ovfWng), 32'h1);
    end_burst();
    check("ovf_valid", 32'(rosterValid), 32'h1);
    check("ovf_count", 32'(rosterCount), 32'h5);
    check("ovf_flat", 32'(rosterFlat), 32'hDCBA9);
    check("ovf_sticky", 32'(ovfWng), 32'h1);
    check("ovf_disp0", 32'(dispID), 32'h9);
    tick();

    // team mismatch, restart clears ovfWng
    beat(4'h2, 1'b0);
    check("tm_ovf_cleared", 32'(ovfWng), 32'h0);
    check("tm_active_drop", 32'(dispActive), 32'h0);
    beat(4'hA, 1'b1);
    check("tm_err_set", 32'(teamErr), 32'h1);
    beat(4'h4, 1'b1);
    end_burst();
    check("tm_count", 32'(rosterCount), 32'h2);
    check("tm_flat", 32'(rosterFlat), 32'h00042);
    check("tm_err_sticky", 32'(teamErr), 32'h1);
    check("tm_disp0", 32'(dispID), 32'h2);

    // restart mid-dwell with 6
    tick();
    tick();
    beat(4'h6, 1'b0);
    check("rs_active", 32'(dispActive), 32'h0);
    check("rs_flags", 32'({ovfWng, teamErr}), 32'h0);
    check("rs_count", 32'(rosterCount), 32'h1);
    check("rs_flat", 32'(rosterFlat), 32'h00006);
    end_burst();
    check("rs_valid", 32'(rosterValid), 32'h1);
    check("rs_disp0", 32'(dispID), 32'h6);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("rs_single_id", 32'(dispID), 32'h6);
      check("rs_single_idx", 32'(dispIdx), 32'h0);
    end

    // empty burst
    for (int k = 0; k < DEPTH; k++) beat(4'h0, 1'b0);
    end_burst();
    check("emp_valid", 32'(rosterValid), 32'h1);
    check("emp_count", 32'(rosterCount), 32'h0);
    check("emp_state_idle", 32'(o_dbg_state), 32'h0);
    check("emp_active", 32'(dispActive), 32'h0);
    tick();
    check("emp_valid_pulse", 32'(rosterValid), 32'h0);
    check("emp_active_stays", 32'(dispActive), 32'h0);

    // reset during the third beat
    beat(4'h1, 1'b0);
    beat(4'h2, 1'b0);
    RST_N = 1'b0;
    beat(4'h3, 1'b0);
    check("mrst_state", 32'(o_dbg_state), 32'h0);
    check("mrst_count", 32'(rosterCount), 32'h0);
    check("mrst_flat", 32'(rosterFlat), 32'h0);
    check("mrst_outs", 32'({rosterValid, dispActive, dispID, dispIdx, ovfWng, teamErr}), 32'h0);
    RST_N = 1'b1;
    end_burst();
    beat(4'h7, 1'b0);
    beat(4'h4, 1'b0);
    end_burst();
    check("mrst_after_valid", 32'(rosterValid), 32'h1);
    check("mrst_after_count", 32'(rosterCount), 32'h2);
    check("mrst_after_flat", 32'(rosterFlat), 32'h00047);

    // duplicate IDs
    beat(4'h3, 1'b0);
    beat(4'h3, 1'b0);
    end_burst();
`ifdef ROSTER_DUP_CHECK_EN
    check("dup_count", 32'(rosterCount), 32'h1);
    check("dup_flat", 32'(rosterFlat), 32'h00003);
    check("dup_wng", 32'(dupWng), 32'h1);
`else
    check("dup_count", 32'(rosterCount), 32'h2);
    check("dup_flat", 32'(rosterFlat), 32'h00033);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
